// File: rtl/sys_load_dump_pkg.sv
// Shared types and constants for the host-link load/dump block.
package sys_load_dump_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  // Top-level sequencing.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DUMP_REG,
    DUMP_MEM,
    FIN
  } state_t;

  // Which source feeds the output stage during a dump.
  // PH_DRAIN means every word has been pushed and the block is waiting
  // for the final word to be taken.
  typedef enum logic [1:0] {
    PH_REG,
    PH_MEM,
    PH_SUM,
    PH_DRAIN
  } dump_phase_t;

endpackage

// File: rtl/stream_out_reg.sv
// One-entry output holding register with valid/ready hold logic.
// Sustains one word per cycle under continuous ready; data and last
// stay frozen while the consumer stalls.
module stream_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  output logic         load_ok,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  // The register may take a new word when empty or when its word leaves now.
  assign load_ok = !out_valid || out_ready;

  // Hold register: refill on load_ok, otherwise keep the stalled word.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load_ok) begin
      out_valid <= push;
      out_last  <= push & push_last;
      if (push) out_data <= push_data;
    end
  end

endmodule

// File: rtl/sys_load_dump.sv
// Program-load / state-dump sequencer between a host link and the CPU.
// Loads a counted word stream into IMEM/DMEM with the CPU held idle, runs
// the CPU until halt, then streams out the register file and a DMEM window.
// Optional feature macro: LOAD_DUMP_CHECKSUM_EN (appends a dump checksum
// word and exposes load_sum).
module sys_load_dump
  import sys_load_dump_pkg::*;
#(
  parameter int MEM_WORDS  = 1024,
  parameter int DUMP_WORDS = 1024,
  parameter int NUM_REGS   = 32,
  localparam int AW        = $clog2(MEM_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_data,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic [REG_IDX_W-1:0] rf_raddr,
  input  logic [XLEN-1:0]      rf_rdata,
  output logic                 cpu_run,
  input  logic                 cpu_halt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_data,
  output logic                 out_last,
  output logic                 done
`ifdef LOAD_DUMP_CHECKSUM_EN
  ,
  output logic [XLEN-1:0]      load_sum
`endif
);

  localparam logic [REG_IDX_W-1:0] LAST_REG  = REG_IDX_W'(NUM_REGS - 1);
  localparam logic [AW-1:0]        LAST_MEM  = AW'(DUMP_WORDS - 1);
  localparam logic [XLEN-1:0]      MEM_LIMIT = XLEN'(MEM_WORDS);

  state_t          state;
  dump_phase_t     phase;
  logic [XLEN-1:0] count;
  logic [XLEN-1:0] index;
  logic            load_fin;

  logic            push;
  logic            push_last;
  logic [XLEN-1:0] push_data;
  logic            load_ok;

`ifdef LOAD_DUMP_CHECKSUM_EN
  logic [XLEN-1:0] dump_sum;
`endif

  // Select the word offered to the output stage for the current dump phase.
  // NOTE: every signal gets a default first so no path infers a latch.
  always_comb begin
    push      = 1'b0;
    push_last = 1'b0;
    push_data = rf_rdata;
    case (state)
      DUMP_REG: push = 1'b1;
      DUMP_MEM: begin
        case (phase)
          PH_MEM: begin
            push      = 1'b1;
            push_data = mem_rdata;
`ifdef LOAD_DUMP_CHECKSUM_EN
            push_last = 1'b0;
`else
            push_last = (mem_addr == LAST_MEM);
`endif
          end
`ifdef LOAD_DUMP_CHECKSUM_EN
          PH_SUM: begin
            push      = 1'b1;
            push_data = dump_sum;
            push_last = 1'b1;
          end
`endif
          default: push = 1'b0;
        endcase
      end
      default: push = 1'b0;
    endcase
  end

  stream_out_reg #(.W(XLEN)) u_out (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .push_last (push_last),
    .load_ok   (load_ok),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  // Main sequencer with registered host, memory and CPU control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= PH_REG;
      count     <= '0;
      index     <= '0;
      load_fin  <= 1'b0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rf_raddr  <= '0;
      cpu_run   <= 1'b0;
      done      <= 1'b0;
`ifdef LOAD_DUMP_CHECKSUM_EN
      dump_sum  <= '0;
      load_sum  <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            count <= in_data;
            index <= '0;
            if (in_data == '0) begin
              state    <= RUN;
              cpu_run  <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              state <= LOAD;
            end
          end
        end

        LOAD: begin
          // The extra cycle after the last word keeps cpu_run clear of
          // the final memory write.
          if (load_fin) begin
            load_fin <= 1'b0;
            state    <= RUN;
            cpu_run  <= 1'b1;
          end else if (in_valid && in_ready) begin
            if (index < MEM_LIMIT) begin
              mem_we    <= 1'b1;
              mem_addr  <= index[AW-1:0];
              mem_wdata <= in_data;
            end
            index <= index + 1'b1;
`ifdef LOAD_DUMP_CHECKSUM_EN
            load_sum <= load_sum + in_data;
`endif
            if (index == count - 1'b1) begin
              in_ready <= 1'b0;
              load_fin <= 1'b1;
            end
          end
        end

        RUN: begin
          if (cpu_halt) begin
            state    <= DUMP_REG;
            phase    <= PH_REG;
            cpu_run  <= 1'b0;
            rf_raddr <= '0;
          end
        end

        DUMP_REG: begin
          if (load_ok) begin
`ifdef LOAD_DUMP_CHECKSUM_EN
            dump_sum <= dump_sum + push_data;
`endif
            if (rf_raddr == LAST_REG) begin
              state    <= DUMP_MEM;
              phase    <= PH_MEM;
              mem_addr <= '0;
            end else begin
              rf_raddr <= rf_raddr + 1'b1;
            end
          end
        end

        DUMP_MEM: begin
          case (phase)
            PH_MEM: begin
              if (load_ok) begin
`ifdef LOAD_DUMP_CHECKSUM_EN
                dump_sum <= dump_sum + push_data;
`endif
                if (mem_addr == LAST_MEM) begin
`ifdef LOAD_DUMP_CHECKSUM_EN
                  phase <= PH_SUM;
`else
                  phase <= PH_DRAIN;
`endif
                end else begin
                  mem_addr <= mem_addr + 1'b1;
                end
              end
            end
            PH_SUM: begin
              if (load_ok) phase <= PH_DRAIN;
            end
            default: begin
              // Final word leaves this edge; the stage empties itself.
              if (out_valid && out_ready) begin
                state <= FIN;
                done  <= 1'b1;
              end
            end
          endcase
        end

        default: begin
          done <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_load_dump.sv
// Directed bench for sys_load_dump: load, run/halt, dump with and without
// back-pressure, mid-load reset and load overflow. Honours
// LOAD_DUMP_CHECKSUM_EN when defined.
module tb_sys_load_dump;

  localparam int MEM_WORDS  = 4;
  localparam int DUMP_WORDS = 4;
  localparam int NUM_REGS   = 32;
  localparam int AW         = $clog2(MEM_WORDS);
`ifdef LOAD_DUMP_CHECKSUM_EN
  localparam int EXP_N      = NUM_REGS + DUMP_WORDS + 1;
`else
  localparam int EXP_N      = NUM_REGS + DUMP_WORDS;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [4:0]    rf_raddr;
  logic [31:0]   rf_rdata;
  logic          cpu_run;
  logic          cpu_halt;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_last;
  logic          done;
`ifdef LOAD_DUMP_CHECKSUM_EN
  logic [31:0]   load_sum;
`endif

  logic [31:0] rf_m   [NUM_REGS];
  logic [31:0] dmem_m [MEM_WORDS];
  logic [31:0] exp_w  [EXP_N];
  logic [31:0] wq     [$];

  int vectors;
  int miscompares;

  sys_load_dump #(
    .MEM_WORDS  (MEM_WORDS),
    .DUMP_WORDS (DUMP_WORDS),
    .NUM_REGS   (NUM_REGS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .cpu_run   (cpu_run),
    .cpu_halt  (cpu_halt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done)
`ifdef LOAD_DUMP_CHECKSUM_EN
    ,
    .load_sum  (load_sum)
`endif
  );

  assign mem_rdata = dmem_m[mem_addr];
  assign rf_rdata  = rf_m[rf_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " in_ready"},  32'(in_ready),  32'h0);
    check({tag, " mem_we"},    32'(mem_we),    32'h0);
    check({tag, " mem_addr"},  32'(mem_addr),  32'h0);
    check({tag, " mem_wdata"}, mem_wdata,      32'h0);
    check({tag, " rf_raddr"},  32'(rf_raddr),  32'h0);
    check({tag, " cpu_run"},   32'(cpu_run),   32'h0);
    check({tag, " out_valid"}, 32'(out_valid), 32'h0);
    check({tag, " out_data"},  out_data,       32'h0);
    check({tag, " out_last"},  32'(out_last),  32'h0);
    check({tag, " done"},      32'(done),      32'h0);
`ifdef LOAD_DUMP_CHECKSUM_EN
    check({tag, " load_sum"},  load_sum,       32'h0);
`endif
  endtask

  // Bounded wait for in_ready, sampled on the falling edge.
  task automatic wait_ready(input string tag);
    for (int k = 0; k < 10 && !in_ready; k++) @(negedge clk);
    check({tag, " in_ready"}, 32'(in_ready), 32'h1);
  endtask

  // Send count wq.size() followed by the words of wq, checking each write.
  task automatic do_load(input string tag);
    wait_ready(tag);
    in_valid = 1'b1;
    in_data  = 32'(wq.size());
    @(negedge clk);
    check({tag, " we after count"}, 32'(mem_we), 32'h0);
    for (int i = 0; i < wq.size(); i++) begin
      in_data = wq[i];
      @(negedge clk);
      check($sformatf("%s we[%0d]", tag, i), 32'(mem_we), 32'(i < MEM_WORDS));
      if (i < MEM_WORDS) begin
        check($sformatf("%s addr[%0d]", tag, i), 32'(mem_addr), 32'(i));
        check($sformatf("%s wdata[%0d]", tag, i), mem_wdata, wq[i]);
      end
      check($sformatf("%s cpu_run[%0d]", tag, i), 32'(cpu_run), 32'h0);
    end
    in_valid = 1'b0;
    in_data  = '0;
    @(negedge clk);
    check({tag, " cpu_run rise"}, 32'(cpu_run), 32'h1);
    check({tag, " we idle"},      32'(mem_we),  32'h0);
    check({tag, " in_ready low"}, 32'(in_ready), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] sum;
    logic [31:0] prev_data;
    logic        prev_stall;
    int          got;

    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    cpu_halt  = 1'b0;
    out_ready = 1'b0;

    for (int i = 0; i < NUM_REGS; i++) rf_m[i] = 32'(i * 4);
    for (int j = 0; j < MEM_WORDS; j++) dmem_m[j] = 32'hA000_0000 + 32'(j);
    sum = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_w[i] = 32'(i * 4);
      sum      = sum + exp_w[i];
    end
    for (int j = 0; j < DUMP_WORDS; j++) begin
      exp_w[NUM_REGS + j] = 32'hA000_0000 + 32'(j);
      sum                 = sum + exp_w[NUM_REGS + j];
    end
`ifdef LOAD_DUMP_CHECKSUM_EN
    exp_w[EXP_N - 1] = sum;
`endif

    // Reset state.
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // Load three words with in_valid held high.
    wq = '{32'h11, 32'h22, 32'h33};
    do_load("load3");
`ifdef LOAD_DUMP_CHECKSUM_EN
    check("load3 load_sum", load_sum, 32'h66);
`endif

    // Halt and dump with continuous out_ready.
    cpu_halt  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    cpu_halt = 1'b0;
    check("halt cpu_run", 32'(cpu_run), 32'h0);
    check("halt no valid yet", 32'(out_valid), 32'h0);
    for (int i = 0; i < EXP_N; i++) begin
      @(negedge clk);
      check($sformatf("dump valid[%0d]", i), 32'(out_valid), 32'h1);
      check($sformatf("dump data[%0d]", i),  out_data, exp_w[i]);
      check($sformatf("dump last[%0d]", i),  32'(out_last), 32'(i == EXP_N - 1));
    end
    @(negedge clk);
    check("dump end valid", 32'(out_valid), 32'h0);
    check("dump done",      32'(done),      32'h1);
    out_ready = 1'b0;

    // Empty load, halt five cycles later, dump under back-pressure.
    do_reset();
    wait_ready("load0");
    in_valid = 1'b1;
    in_data  = 32'h0;
    @(negedge clk);
    in_valid = 1'b0;
    check("load0 cpu_run", 32'(cpu_run), 32'h1);
    check("load0 we",      32'(mem_we),  32'h0);
    for (int k = 0; k < 4; k++) @(negedge clk);
    check("load0 cpu_run held", 32'(cpu_run), 32'h1);
    cpu_halt = 1'b1;
    @(negedge clk);
    cpu_halt = 1'b0;
    check("load0 halt cpu_run", 32'(cpu_run), 32'h0);

    got        = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      out_ready = cyc[0];
      if (prev_stall) begin
        check($sformatf("stall valid[%0d]", cyc), 32'(out_valid), 32'h1);
        check($sformatf("stall data[%0d]", cyc),  out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (got < EXP_N) begin
          check($sformatf("bp data[%0d]", got), out_data, exp_w[got]);
          check($sformatf("bp last[%0d]", got), 32'(out_last), 32'(got == EXP_N - 1));
        end else begin
          check("bp extra word", 32'(got), 32'(EXP_N - 1));
        end
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      @(negedge clk);
    end
    check("bp word count", 32'(got), 32'(EXP_N));
    check("bp done",       32'(done), 32'h1);
    check("bp end valid",  32'(out_valid), 32'h0);
    out_ready = 1'b0;

    // Reset in the middle of a five-word load, after two words.
    do_reset();
    wait_ready("abort");
    in_valid = 1'b1;
    in_data  = 32'd5;
    @(negedge clk);
    in_data = 32'hAA;
    @(negedge clk);
    in_data = 32'hBB;
    @(negedge clk);
    check("abort pre we", 32'(mem_we), 32'h1);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check_reset_vals("abort");
    @(negedge clk);
    rst = 1'b0;

    // A new count is accepted after the abort.
    wq = '{32'h1, 32'h2};
    do_load("reload");
`ifdef LOAD_DUMP_CHECKSUM_EN
    check("reload load_sum", load_sum, 32'h3);
`endif

    // Overflow: the fifth word is consumed but not written.
    do_reset();
    wq = '{32'h51, 32'h52, 32'h53, 32'h54, 32'h55};
    do_load("ovf");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sys_load_dump.md
Name: sys_load_dump

Overview:
- Hardware counterpart of the bench's program-load and state-dump steps.
- Accepts a word stream and writes it into IMEM and DMEM while holding the CPU idle, then releases the CPU to run.
- On CPU halt, reads out the register file and a DMEM window as an outbound word stream.
- Sits between an external host link and the CPU's memory and register-file side ports.

Parameters:
- MEM_WORDS, 1024: load capacity in 32-bit words; address width AW = $clog2(MEM_WORDS).
- DUMP_WORDS, 1024: number of DMEM words dumped after the registers; must be <= MEM_WORDS.
- NUM_REGS, 32: register-file entries dumped.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  load-stream word valid.
- in_ready  out  1  load-stream ready.
- in_data  in  32  load-stream word.
- mem_we  out  1  write strobe, shared by IMEM and DMEM.
- mem_addr  out  AW  word index for both the load write and the dump read.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  DMEM combinational read data at mem_addr.
- rf_raddr  out  5  register-file read index.
- rf_rdata  in  32  register-file combinational read data.
- cpu_run  out  1  high lets the CPU execute; the CPU is held in reset while low.
- cpu_halt  in  1  CPU halt flag.
- out_valid  out  1  dump word valid.
- out_ready  in  1  dump consumer ready.
- out_data  out  32  dump word.
- out_last  out  1  marks the final dump word.
- done  out  1  sticky flag: dump complete.

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, rf_raddr=0, cpu_run=0, out_valid=0, out_data=0, out_last=0, done=0. Reset asserted mid-operation aborts immediately and returns to IDLE.
- States: IDLE, LOAD, RUN, DUMP_REG, DUMP_MEM, FIN.
- Handshakes: a word transfers on any cycle with valid & ready high on the same edge.
- IDLE:
  - in_ready=1.
  - First accepted word is the count N, latched into a 32-bit register.
  - N=0 -> RUN; otherwise -> LOAD, index=0.
- LOAD:
  - in_ready=1.
  - Each accepted word is registered: the cycle after acceptance, mem_we=1, mem_addr=index, mem_wdata=word; index then increments.
  - Words with index >= MEM_WORDS are consumed but not written (mem_we stays 0).
  - After word N is accepted -> RUN.
- RUN:
  - cpu_run=1 from the first RUN cycle; this is always at least one cycle after the last mem_we.
  - in_ready=0.
  - cpu_halt is ignored in every state except RUN.
  - cpu_halt=1 sampled -> DUMP_REG; cpu_run drops to 0 on the same edge.
- Output stage (one 32-bit holding register):
  - Loads a new word when !out_valid or (out_valid & out_ready).
  - out_data and out_last stay stable while out_valid & !out_ready.
  - Supports one word per cycle under continuous out_ready.
- DUMP_REG:
  - Streams rf_rdata for rf_raddr = 0 .. NUM_REGS-1 in order.
  - The first out_valid appears the cycle after entering DUMP_REG.
- DUMP_MEM:
  - Streams mem_rdata for mem_addr = 0 .. DUMP_WORDS-1.
  - out_last=1 on the final word only.
- FIN:
  - Entered once the last word is accepted.
  - done=1, out_valid=0, and the block remains in FIN until reset.
- Total dump length: NUM_REGS + DUMP_WORDS words (plus one with the optional feature).
- All counters are unsigned. The index wraps only through reset, never in normal operation.

Optional Feature:
- Macro: LOAD_DUMP_CHECKSUM_EN.
- Defined:
  - A 32-bit modulo-2^32 sum of every dumped word is accumulated.
  - It is emitted as one extra final word; out_last moves to that word.
  - Separately, a sum of all loaded data words (excluding N) is kept and exposed on an extra output port load_sum[31:0], reset 0.
- Undefined:
  - No accumulators and no load_sum port.
  - The dump ends on the last DMEM word.

Decomposition:
- Shared package sys_load_dump_pkg:
  - State enum type.
  - Constants XLEN=32 and REG_IDX_W=5.
  - Dump-phase encoding.
- One sub-module, stream_out_reg: the output holding register with valid/ready hold logic. It is reusable by other host-link blocks.

Test Plan:
- Load N=3 (words 0x11,0x22,0x33), in_valid held high -> mem_we pulses at indices 0,1,2 with those data; cpu_run rises 1 cycle after the third write.
- Load N=0 -> no mem_we; cpu_run=1 the cycle after the count is accepted; cpu_halt asserted 5 cycles later -> cpu_run=0 on the next edge.
- Halt with RF[i]=i*4 and DMEM[j]=0xA0000000+j, DUMP_WORDS=4, out_ready=1 -> 36 consecutive words in order; out_last only on 0xA0000003; done=1 afterwards.
- out_ready toggled every other cycle during the dump -> no words dropped or duplicated; out_data stable while stalled.
- rst pulsed mid-LOAD after 2 of 5 words -> all outputs at reset values; a new count is accepted in IDLE.
- With LOAD_DUMP_CHECKSUM_EN, load 0x1,0x2 and dump -> load_sum=0x3; the final dump word equals the sum of all preceding dump words and carries out_last.
